// File: rtl/flop_arbiter.sv
// Round-robin front end that shares one external combinational float adder between REQ_N requesters.
// One operation in flight at a time: IDLE (grant) -> EXEC (adder sees registered operands) -> RESP (hold result).
module flop_arbiter #(
    parameter int REQ_N = 2,
    parameter int IDW   = 1,
    parameter int W     = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ_N-1:0]   req_valid,
    output logic [REQ_N-1:0]   req_ready,
    input  logic [W*REQ_N-1:0] req_a,
    input  logic [W*REQ_N-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W-1:0]       rsp_data,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       add_one,
    output logic [W-1:0]       add_other,
    input  logic [W-1:0]       add_result,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [IDW-1:0]   r_last_grant;
    logic [IDW-1:0]   r_id;
    logic [W-1:0]     r_op_a;
    logic [W-1:0]     r_op_b;
    logic [W-1:0]     r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_valid;

    logic [IDW-1:0]   w_grant;
    logic             w_grant_found;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic             w_accept;
    int               w_idx;

    // Scan from last_grant+REQ_N down to last_grant+1 so the closest requester after last_grant wins.
    always_comb begin
        w_grant       = '0;
        w_grant_found = 1'b0;
        w_idx         = 0;
        for (int k = REQ_N; k >= 1; k--) begin
            w_idx = (int'(r_last_grant) + k) % REQ_N;
            for (int i = 0; i < REQ_N; i++) begin
                if (i == w_idx && req_valid[i]) begin
                    w_grant       = IDW'(i);
                    w_grant_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (w_grant == IDW'(i)) begin
                w_sel_a = req_a[W*i +: W];
                w_sel_b = req_b[W*i +: W];
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_grant_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_found) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Ready is gated by rst_n so a held req_valid cannot see a grant while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && rst_n && w_grant_found) begin
            for (int i = 0; i < REQ_N; i++) begin
                if (w_grant == IDW'(i)) req_ready[i] = 1'b1;
            end
        end
        busy = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDW'(REQ_N - 1);
            r_id         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_rsp_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a       <= w_sel_a;
                r_op_b       <= w_sel_b;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == EXEC) begin
                r_rsp_data  <= add_result;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == RESP && r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign add_one   = r_op_a;
    assign add_other = r_op_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_flop_arbiter.sv
// Directed bench for flop_arbiter with a behavioural {sign, mant[7:0], exp[3:0]} adder on the add_* ports.
module tb_flop_arbiter;

    localparam int REQ_N = 2;
    localparam int IDW   = 1;
    localparam int W     = 13;

    logic               clk;
    logic               rst_n;
    logic [REQ_N-1:0]   reqValid;
    logic [REQ_N-1:0]   reqReady;
    logic [W*REQ_N-1:0] reqA;
    logic [W*REQ_N-1:0] reqB;
    logic               rspValid;
    logic               rspReady;
    logic [W-1:0]       rspData;
    logic [IDW-1:0]     rspId;
    logic [W-1:0]       addOne;
    logic [W-1:0]       addOther;
    logic [W-1:0]       addResult;
    logic               busy;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic [1:0]  valid;
        logic        rspRdy;
        logic [1:0]  expReady;
        logic        expRv;
        logic [12:0] expData;
        logic        expId;
        logic        expBusy;
        logic [12:0] expAdd1;
        logic [12:0] expAdd2;
    } vec_t;

    vec_t tbl [15];

    flop_arbiter #(.REQ_N(REQ_N), .IDW(IDW), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_a      (reqA),
        .req_b      (reqB),
        .rsp_valid  (rspValid),
        .rsp_ready  (rspReady),
        .rsp_data   (rspData),
        .rsp_id     (rspId),
        .add_one    (addOne),
        .add_other  (addOther),
        .add_result (addResult),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external adder: align, add signed magnitudes, renormalise to mant[7]=1, flush underflow.
    function automatic logic [12:0] fadd(input logic [12:0] x, input logic [12:0] y);
        int ma, mb, ea, eb, e, s, mag;
        logic sg;
        ma = int'(x[11:4]);
        mb = int'(y[11:4]);
        ea = int'(x[3:0]);
        eb = int'(y[3:0]);
        if (ea >= eb) begin
            e  = ea;
            mb = mb >> (ea - eb);
        end else begin
            e  = eb;
            ma = ma >> (eb - ea);
        end
        s = (x[12] ? -ma : ma) + (y[12] ? -mb : mb);
        if (s == 0) return {y[12], 12'h000};
        sg  = (s < 0);
        mag = sg ? -s : s;
        if (mag > 255) begin
            mag = mag >> 1;
            e   = e + 1;
        end
        if (e > 15) begin
            e   = 15;
            mag = 255;
        end
        for (int k = 0; k < 8; k++) begin
            if (mag < 128 && e > 0) begin
                mag = mag << 1;
                e   = e - 1;
            end
        end
        if (mag < 128) return {sg, 12'h000};
        return {sg, mag[7:0], e[3:0]};
    endfunction

    always_comb addResult = fadd(addOne, addOther);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reqValid = v.valid;
        rspReady = v.rspRdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    int grantCyc [8];
    int gCount;
    int rCount;

    initial begin
        // valid, rspRdy, expReady, expRv, expData, expId, expBusy, expAdd1, expAdd2
        tbl[0]  = '{2'b01, 1'b0, 2'b01, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 13'h0000};
        tbl[1]  = '{2'b00, 1'b0, 2'b00, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0801, 13'h0801};
        tbl[2]  = '{2'b10, 1'b0, 2'b00, 1'b1, 13'h0802, 1'b0, 1'b1, 13'h0801, 13'h0801};
        tbl[3]  = '{2'b00, 1'b1, 2'b00, 1'b1, 13'h0802, 1'b0, 1'b1, 13'h0801, 13'h0801};
        tbl[4]  = '{2'b00, 1'b1, 2'b00, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0801, 13'h0801};
        tbl[5]  = '{2'b10, 1'b1, 2'b10, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0801, 13'h0801};
        tbl[6]  = '{2'b00, 1'b1, 2'b00, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0801, 13'h1801};
        tbl[7]  = '{2'b00, 1'b1, 2'b00, 1'b1, 13'h1000, 1'b1, 1'b1, 13'h0801, 13'h1801};
        tbl[8]  = '{2'b11, 1'b0, 2'b01, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0801, 13'h1801};
        tbl[9]  = '{2'b11, 1'b0, 2'b00, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0801, 13'h0801};
        tbl[10] = '{2'b11, 1'b1, 2'b00, 1'b1, 13'h0802, 1'b0, 1'b1, 13'h0801, 13'h0801};
        tbl[11] = '{2'b11, 1'b0, 2'b10, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0801, 13'h0801};
        tbl[12] = '{2'b00, 1'b0, 2'b00, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0801, 13'h1801};
        tbl[13] = '{2'b00, 1'b1, 2'b00, 1'b1, 13'h1000, 1'b1, 1'b1, 13'h0801, 13'h1801};
        tbl[14] = '{2'b00, 1'b0, 2'b00, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0801, 13'h1801};

        rst_n    = 1'b0;
        reqValid = 2'b11;
        rspReady = 1'b0;
        reqA     = {13'h0801, 13'h0801};
        reqB     = {13'h1801, 13'h0801};
        #12;
        checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_rsp_data",  32'(rspData),  32'd0);
        checkOutput("rst_rsp_id",    32'(rspId),    32'd0);
        checkOutput("rst_add_one",   32'(addOne),   32'd0);
        checkOutput("rst_add_other", 32'(addOther), 32'd0);
        checkOutput("rst_busy",      32'(busy),     32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        reqValid = 2'b00;
        nextCycle();

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("tbl%0d_req_ready", i), 32'(reqReady), 32'(tbl[i].expReady));
            checkOutput($sformatf("tbl%0d_rsp_valid", i), 32'(rspValid), 32'(tbl[i].expRv));
            checkOutput($sformatf("tbl%0d_busy", i),      32'(busy),     32'(tbl[i].expBusy));
            checkOutput($sformatf("tbl%0d_add_one", i),   32'(addOne),   32'(tbl[i].expAdd1));
            checkOutput($sformatf("tbl%0d_add_other", i), 32'(addOther), 32'(tbl[i].expAdd2));
            if (tbl[i].expRv) begin
                checkOutput($sformatf("tbl%0d_rsp_data", i), 32'(rspData), 32'(tbl[i].expData));
                checkOutput($sformatf("tbl%0d_rsp_id", i),   32'(rspId),   32'(tbl[i].expId));
            end
            nextCycle();
        end

        // Both requesters valid every cycle: expect alternating ids and a grant every third cycle.
        reqA     = {13'h0903, 13'h0801};
        reqB     = {13'h0802, 13'h0801};
        reqValid = 2'b11;
        rspReady = 1'b1;
        gCount   = 0;
        rCount   = 0;
        for (int cyc = 0; cyc < 30 && rCount < 6; cyc++) begin
            @(negedge clk);
            if (reqReady != 2'b00 && gCount < 8) begin
                grantCyc[gCount] = cyc;
                gCount++;
            end
            if (rspValid) begin
                checkOutput($sformatf("rr_id%0d", rCount), 32'(rspId), 32'(rCount % 2));
                checkOutput($sformatf("rr_data%0d", rCount), 32'(rspData),
                            (rCount % 2 == 0) ? 32'h0802 : 32'h0D03);
                rCount++;
            end
            nextCycle();
        end
        reqValid = 2'b00;
        checkOutput("rr_resp_count", 32'(rCount), 32'd6);
        for (int k = 1; k < 6; k++) begin
            if (k < gCount)
                checkOutput($sformatf("rr_grant_gap%0d", k), 32'(grantCyc[k] - grantCyc[k-1]), 32'd3);
            else
                checkOutput($sformatf("rr_grant_missing%0d", k), 32'(gCount), 32'd6);
        end

        // Consumer stalls for five RESP cycles while requester 0 keeps asking.
        reqA     = {13'h0801, 13'h0801};
        reqB     = {13'h1801, 13'h0801};
        reqValid = 2'b01;
        rspReady = 1'b0;
        @(negedge clk);
        checkOutput("stall_grant", 32'(reqReady), 32'h1);
        nextCycle();
        @(negedge clk);
        checkOutput("stall_exec_ready", 32'(reqReady), 32'h0);
        nextCycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d_rsp_valid", k), 32'(rspValid), 32'h1);
            checkOutput($sformatf("stall%0d_rsp_data", k),  32'(rspData),  32'h0802);
            checkOutput($sformatf("stall%0d_rsp_id", k),    32'(rspId),    32'h0);
            checkOutput($sformatf("stall%0d_req_ready", k), 32'(reqReady), 32'h0);
            checkOutput($sformatf("stall%0d_busy", k),      32'(busy),     32'h1);
            nextCycle();
        end
        rspReady = 1'b1;
        @(negedge clk);
        checkOutput("stall_release_valid", 32'(rspValid), 32'h1);
        nextCycle();
        rspReady = 1'b0;
        @(negedge clk);
        checkOutput("stall_regrant", 32'(reqReady), 32'h1);
        checkOutput("stall_idle_busy", 32'(busy), 32'h0);
        nextCycle();

        // Reset lands while the regranted op is in EXEC; it must vanish without a response.
        checkOutput("rst_mid_exec_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_rsp_valid", 32'(rspValid), 32'h0);
        checkOutput("rst_mid_busy",      32'(busy),     32'h0);
        checkOutput("rst_mid_req_ready", 32'(reqReady), 32'h0);
        checkOutput("rst_mid_add_one",   32'(addOne),   32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        reqValid = 2'b00;
        rspReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            @(negedge clk);
            checkOutput($sformatf("post_rst%0d_rsp_valid", k), 32'(rspValid), 32'h0);
            checkOutput($sformatf("post_rst%0d_busy", k),      32'(busy),     32'h0);
        end
        nextCycle();
        reqValid = 2'b11;
        @(negedge clk);
        checkOutput("post_rst_first_grant", 32'(reqReady), 32'h1);
        nextCycle();
        reqValid = 2'b00;
        repeat (4) nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
